zigzag_reorder: RTL

//  Downstream of the 8-bit DCT coefficient output stage in the JPEG encoder path.

---
 rtl/jpeg_pkg.sv | 39 +++
 rtl/zigzag_rom.sv | 11 +
 rtl/zigzag_reorder.sv | 99 +++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG block constants and the zigzag scan table, used by the reorder,
// RLE and huffman stages.
package jpeg_pkg;

  localparam int BLK_SIZE = 64;
  localparam int IDX_W    = 6;

  typedef logic [IDX_W-1:0] blk_idx_t;

  localparam blk_idx_t LAST_IDX  = blk_idx_t'(BLK_SIZE - 1);
  localparam blk_idx_t FIRST_IDX = '0;

  // Maps a position in the zigzag scan to the raster (row-major) index it reads.
  function automatic blk_idx_t zz_addr(input blk_idx_t idx);
    blk_idx_t a;
    a = '0;
    case (idx)
      6'd0:  a = 6'd0;   6'd1:  a = 6'd1;   6'd2:  a = 6'd8;   6'd3:  a = 6'd16;
      6'd4:  a = 6'd9;   6'd5:  a = 6'd2;   6'd6:  a = 6'd3;   6'd7:  a = 6'd10;
      6'd8:  a = 6'd17;  6'd9:  a = 6'd24;  6'd10: a = 6'd32;  6'd11: a = 6'd25;
      6'd12: a = 6'd18;  6'd13: a = 6'd11;  6'd14: a = 6'd4;   6'd15: a = 6'd5;
      6'd16: a = 6'd12;  6'd17: a = 6'd19;  6'd18: a = 6'd26;  6'd19: a = 6'd33;
      6'd20: a = 6'd40;  6'd21: a = 6'd48;  6'd22: a = 6'd41;  6'd23: a = 6'd34;
      6'd24: a = 6'd27;  6'd25: a = 6'd20;  6'd26: a = 6'd13;  6'd27: a = 6'd6;
      6'd28: a = 6'd7;   6'd29: a = 6'd14;  6'd30: a = 6'd21;  6'd31: a = 6'd28;
      6'd32: a = 6'd35;  6'd33: a = 6'd42;  6'd34: a = 6'd49;  6'd35: a = 6'd56;
      6'd36: a = 6'd57;  6'd37: a = 6'd50;  6'd38: a = 6'd43;  6'd39: a = 6'd36;
      6'd40: a = 6'd29;  6'd41: a = 6'd22;  6'd42: a = 6'd15;  6'd43: a = 6'd23;
      6'd44: a = 6'd30;  6'd45: a = 6'd37;  6'd46: a = 6'd44;  6'd47: a = 6'd51;
      6'd48: a = 6'd58;  6'd49: a = 6'd59;  6'd50: a = 6'd52;  6'd51: a = 6'd45;
      6'd52: a = 6'd38;  6'd53: a = 6'd31;  6'd54: a = 6'd39;  6'd55: a = 6'd46;
      6'd56: a = 6'd53;  6'd57: a = 6'd60;  6'd58: a = 6'd61;  6'd59: a = 6'd54;
      6'd60: a = 6'd47;  6'd61: a = 6'd55;  6'd62: a = 6'd62;  6'd63: a = 6'd63;
      default: a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/zigzag_rom.sv
// Combinational zigzag position -> raster address lookup.
module zigzag_rom
  import jpeg_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] addr
);

  assign addr = zz_addr(idx);

endmodule

// File: rtl/zigzag_reorder.sv
// Ping-pong 8x8 block buffer: fills one bank in raster order while the other
// drains in JPEG zigzag order.
module zigzag_reorder
  import jpeg_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sob,
  output logic          out_eob
);

  logic [DW-1:0] mem [2][BLK_SIZE];
  logic [1:0]    full;
  logic          wr_bank;
  logic          rd_bank;
  blk_idx_t      wr_idx;
  blk_idx_t      rd_idx;
  blk_idx_t      rd_addr;
  logic          wr_fire;
  logic          rd_fire;
  logic          wr_last;
  logic          rd_last;

  assign in_ready  = !rst && !full[wr_bank];
  assign out_valid = !rst && full[rd_bank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_last   = wr_fire && (wr_idx == LAST_IDX);
  assign rd_last   = rd_fire && (rd_idx == LAST_IDX);

  zigzag_rom u_rom (
    .idx  (rd_idx),
    .addr (rd_addr)
  );

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank][wr_idx] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      wr_idx <= wr_idx + blk_idx_t'(1);
      if (wr_last) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx  <= '0;
      rd_bank <= 1'b0;
    end else if (rd_fire) begin
      rd_idx <= rd_idx + blk_idx_t'(1);
      if (rd_last) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  // A bank being written is never full and a bank being read always is, so the
  // set and clear below can never target the same bank in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      if (wr_last) begin
        full[wr_bank] <= 1'b1;
      end
      if (rd_last) begin
        full[rd_bank] <= 1'b0;
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = mem[rd_bank][rd_addr];
    end
  end

  assign out_sob = out_valid && (rd_idx == FIRST_IDX);
  assign out_eob = out_valid && (rd_idx == LAST_IDX);

endmodule
